// File: rtl/radius_ctrl_pkg.sv
// Shared types and constants for the radius controller and its player-radius datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: phase_t enum, RADIUS_W, R_MIN, R_MAX, R_INIT, and the phase_onehot() helper.
package eatup_pkg;

   typedef enum logic [1:0] {MENU = 2'd0, RUN = 2'd1, PAUSE = 2'd2, OVER = 2'd3} phase_t;

   localparam int RADIUS_W = 6;
   localparam logic [RADIUS_W-1:0] R_MIN  = 6'd10;
   localparam logic [RADIUS_W-1:0] R_MAX  = 6'd50;
   localparam logic [RADIUS_W-1:0] R_INIT = 6'd50;

   // Bit order of the result is {over, pause, run, menu}.
   function automatic logic [3:0] phase_onehot(phase_t p);
      return 4'b0001 << p;
   endfunction

endpackage

// File: rtl/radius_ctrl_if.sv
// Player-side bundle between the game logic and radius_ctrl.
// Latency: n/a (wires only).
// Backpressure: none; every request is a one-cycle pulse.
// Modports:
//   master : drives btn_start, btn_pause, frame_tick, eat_req, hit_req and r;
//            observes the phase flags, plus, minus and score.
//   slave  : the controller's view, with the directions reversed.
interface radius_ctrl_if
   import eatup_pkg::*;
#(
   parameter int SCORE_W = 8
) ();
   logic                btn_start;
   logic                btn_pause;
   logic                frame_tick;
   logic                eat_req;
   logic                hit_req;
   logic [RADIUS_W-1:0] r;
   logic                gamemenu;
   logic                gamerun;
   logic                gamepause;
   logic                gameover;
   logic                plus;
   logic                minus;
   logic [SCORE_W-1:0]  score;

   modport master (
      output btn_start, btn_pause, frame_tick, eat_req, hit_req, r,
      input  gamemenu, gamerun, gamepause, gameover, plus, minus, score
   );

   modport slave (
      input  btn_start, btn_pause, frame_tick, eat_req, hit_req, r,
      output gamemenu, gamerun, gamepause, gameover, plus, minus, score
   );
endinterface

// File: rtl/radius_ctrl_frame_timer.sv
// Loadable frame down-counter with an is-zero flag. It steps once per enabled frame_tick and stops at 0.
// Latency: the new count (and the zero flag) is visible one cycle after load or tick.
// Backpressure: none. A load takes priority over a decrement in the same cycle.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load, load_val : synchronous load
//   tick, en : decrement qualifiers
//   zero : count == 0
module frame_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   input  logic         en,
   output logic         zero
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (tick && en && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/radius_ctrl.sv
// Game-phase FSM and per-frame grow/shrink arbiter for the player-radius datapath.
// Latency: a plus or minus pulse appears in the cycle after the frame_tick that grants it.
// Backpressure: none. Requests are held in depth-1 pending flags, and repeat requests merge.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : radius_ctrl_if.slave (buttons, frame_tick, eat/hit requests, r; phase flags, plus/minus, score)
// Optional: `define AUTO_SHRINK_EN to add an idle-frame auto-shrink request.
//           It arbitrates as a hit-class request.
module radius_ctrl
   import eatup_pkg::*;
#(
   parameter int HIT_COOLDOWN = 30,
   parameter int SCORE_W      = 8,
   parameter int IDLE_FRAMES  = 600
) (
   input  logic         clk,
   input  logic         rst_n,
   radius_ctrl_if.slave bus
);
   localparam int CD_W = $clog2(HIT_COOLDOWN + 1);

   phase_t             state;
   logic [3:0]         phase_oh;
   logic               plus_q, minus_q;
   logic [SCORE_W-1:0] score_q;
   logic               eat_pend, hit_pend;
   logic               rr_hit;     // 1: the hit class wins the next contested grant
   logic               cd_zero;

   logic in_run, tick_run, new_game, hitc_pend, grant_eat, grant_hitc, grant_hit, hit_over, shrink_minus;

   assign in_run   = (state == RUN);
   assign tick_run = in_run && bus.frame_tick;
   assign new_game = (state == MENU) && bus.btn_start;

`ifdef AUTO_SHRINK_EN
   localparam int IDLE_W = $clog2(IDLE_FRAMES + 1);
   logic shrink_pend, idle_zero, grant_shrink, shrink_set;

   assign hitc_pend    = hit_pend || shrink_pend;
   assign grant_shrink = grant_hitc && !hit_pend;          // a real hit beats an idle shrink
   assign shrink_minus = grant_shrink && (bus.r > R_MIN);  // an idle shrink never ends the game
   // The counter runs IDLE_FRAMES-1 .. 0. The tick that finds it at 0 is the IDLE_FRAMES-th idle frame.
   // An eat grant on that same tick restarts the count instead.
   assign shrink_set   = tick_run && idle_zero && !grant_eat;

   frame_timer #(.W(IDLE_W)) u_idle (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (new_game || grant_eat || shrink_set),
      .load_val (IDLE_W'(IDLE_FRAMES - 1)),
      .tick     (bus.frame_tick),
      .en       (in_run),
      .zero     (idle_zero)
   );
`else
   assign hitc_pend    = hit_pend;
   assign shrink_minus = 1'b0;
`endif

   // Arbitration uses the flags registered before this cycle. A request that arrives with the tick waits.
   assign grant_eat  = tick_run && eat_pend  && (!hitc_pend || !rr_hit);
   assign grant_hitc = tick_run && hitc_pend && (!eat_pend  ||  rr_hit);
   assign grant_hit  = grant_hitc && hit_pend;
   assign hit_over   = grant_hit && (bus.r <= R_MIN);

   // Cooldown is cleared at game start and reloaded by a survivable hit.
   // A load wins over the decrement, so the loading tick does not count down.
   frame_timer #(.W(CD_W)) u_cool (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (new_game || (grant_hit && !hit_over)),
      .load_val (new_game ? '0 : CD_W'(HIT_COOLDOWN)),
      .tick     (bus.frame_tick),
      .en       (in_run),
      .zero     (cd_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= MENU;
         phase_oh <= phase_onehot(MENU);
         plus_q   <= 1'b0;
         minus_q  <= 1'b0;
         score_q  <= '0;
         eat_pend <= 1'b0;
         hit_pend <= 1'b0;
         rr_hit   <= 1'b0;
`ifdef AUTO_SHRINK_EN
         shrink_pend <= 1'b0;
`endif
      end else begin
         plus_q  <= grant_eat && (bus.r < R_MAX);
         minus_q <= (grant_hit && !hit_over) || shrink_minus;

         if (tick_run && eat_pend && hitc_pend)
            rr_hit <= !rr_hit;
         if (grant_eat && (score_q != '1))
            score_q <= score_q + 1'b1;

         // A clear from a grant comes first, so a request in the same cycle re-arms the flag.
         if (grant_eat)                       eat_pend <= 1'b0;
         if (in_run && bus.eat_req)           eat_pend <= 1'b1;
         if (grant_hit)                       hit_pend <= 1'b0;
         if (in_run && bus.hit_req && cd_zero) hit_pend <= 1'b1;
`ifdef AUTO_SHRINK_EN
         if (grant_shrink)                    shrink_pend <= 1'b0;
         if (shrink_set)                      shrink_pend <= 1'b1;
`endif

         // Phase changes come last, so their flag clears override the latching above.
         case (state)
            MENU: if (bus.btn_start) begin
               state    <= RUN;
               phase_oh <= phase_onehot(RUN);
               score_q  <= '0;
               eat_pend <= 1'b0;
               hit_pend <= 1'b0;
`ifdef AUTO_SHRINK_EN
               shrink_pend <= 1'b0;
`endif
            end
            RUN: if (hit_over) begin
               state    <= OVER;
               phase_oh <= phase_onehot(OVER);
               eat_pend <= 1'b0;
               hit_pend <= 1'b0;
`ifdef AUTO_SHRINK_EN
               shrink_pend <= 1'b0;
`endif
            end else if (bus.btn_pause) begin
               state    <= PAUSE;
               phase_oh <= phase_onehot(PAUSE);
            end
            PAUSE: if (bus.btn_start) begin
               state    <= MENU;
               phase_oh <= phase_onehot(MENU);
               eat_pend <= 1'b0;
               hit_pend <= 1'b0;
`ifdef AUTO_SHRINK_EN
               shrink_pend <= 1'b0;
`endif
            end else if (bus.btn_pause) begin
               state    <= RUN;
               phase_oh <= phase_onehot(RUN);
            end
            OVER: if (bus.btn_start) begin
               state    <= MENU;
               phase_oh <= phase_onehot(MENU);
            end
            default: begin
               state    <= MENU;
               phase_oh <= phase_onehot(MENU);
            end
         endcase
      end
   end

   assign bus.gamemenu  = phase_oh[0];
   assign bus.gamerun   = phase_oh[1];
   assign bus.gamepause = phase_oh[2];
   assign bus.gameover  = phase_oh[3];
   assign bus.plus      = plus_q;
   assign bus.minus     = minus_q;
   assign bus.score     = score_q;
endmodule

// File: tb/tb_radius_ctrl.sv
// Directed testbench for radius_ctrl. Each scenario task drives pulses and checks the outputs inline.
// Inputs change 1 ns after a rising edge, and outputs are sampled at that same point.
// With AUTO_SHRINK_EN defined, only the short scenarios and the shrink scenarios run (IDLE_FRAMES=4).
module tb_radius_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   radius_ctrl_if #(.SCORE_W(8)) bus ();

   radius_ctrl #(.HIT_COOLDOWN(30), .SCORE_W(8), .IDLE_FRAMES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.btn_start = 0; bus.btn_pause = 0; bus.frame_tick = 0;
      bus.eat_req = 0; bus.hit_req = 0; bus.r = 6'd30;
      rst_n = 0;
      step(); step();
      rst_n = 1;
      step();
   endtask

   task automatic tick();   bus.frame_tick = 1; step(); bus.frame_tick = 0; endtask
   task automatic eat();    bus.eat_req = 1;    step(); bus.eat_req = 0;    endtask
   task automatic hit();    bus.hit_req = 1;    step(); bus.hit_req = 0;    endtask
   task automatic start();  bus.btn_start = 1;  step(); bus.btn_start = 0;  endtask
   task automatic pause();  bus.btn_pause = 1;  step(); bus.btn_pause = 0;  endtask

   task automatic test_reset();
      do_reset();
      checks++; if ({bus.gamemenu, bus.gamerun, bus.gamepause, bus.gameover} !== 4'b1000) begin errors++; $display("FAIL reset_phase got %b want 1000", {bus.gamemenu, bus.gamerun, bus.gamepause, bus.gameover}); end
      checks++; if ({bus.plus, bus.minus} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {bus.plus, bus.minus}); end
      checks++; if (bus.score !== 8'd0) begin errors++; $display("FAIL reset_score got %0d want 0", bus.score); end
   endtask

   task automatic test_eat();
      do_reset(); start(); bus.r = 6'd30;
      eat(); tick();
      checks++; if (bus.plus !== 1'b1) begin errors++; $display("FAIL eat_plus got %b want 1", bus.plus); end
      checks++; if (bus.score !== 8'd1) begin errors++; $display("FAIL eat_score got %0d want 1", bus.score); end
      checks++; if (bus.gamerun !== 1'b1) begin errors++; $display("FAIL eat_run got %b want 1", bus.gamerun); end
      step();
      checks++; if (bus.plus !== 1'b0) begin errors++; $display("FAIL eat_plus_width got %b want 0", bus.plus); end
   endtask

   task automatic test_reset_mid();
      do_reset(); start(); bus.r = 6'd30;
      eat(); tick();
      checks++; if (bus.plus !== 1'b1) begin errors++; $display("FAIL mid_plus got %b want 1", bus.plus); end
      rst_n = 0; #1;
      checks++; if ({bus.plus, bus.gamemenu, bus.score} !== {1'b0, 1'b1, 8'd0}) begin errors++; $display("FAIL mid_reset got plus=%b menu=%b score=%0d want 0 1 0", bus.plus, bus.gamemenu, bus.score); end
      rst_n = 1;
      step();
   endtask

   task automatic test_contest();
      do_reset(); start(); bus.r = 6'd30;
      bus.eat_req = 1; bus.hit_req = 1; step(); bus.eat_req = 0; bus.hit_req = 0;
      tick();
      checks++; if ({bus.plus, bus.minus} !== 2'b10) begin errors++; $display("FAIL contest1_first got %b want 10", {bus.plus, bus.minus}); end
      tick();
      checks++; if ({bus.plus, bus.minus} !== 2'b01) begin errors++; $display("FAIL contest1_second got %b want 01", {bus.plus, bus.minus}); end
      for (int i = 0; i < 30; i++) tick();   // let the hit cooldown run out
      bus.eat_req = 1; bus.hit_req = 1; step(); bus.eat_req = 0; bus.hit_req = 0;
      tick();
      checks++; if ({bus.plus, bus.minus} !== 2'b01) begin errors++; $display("FAIL contest2_first got %b want 01", {bus.plus, bus.minus}); end
      tick();
      checks++; if ({bus.plus, bus.minus} !== 2'b10) begin errors++; $display("FAIL contest2_second got %b want 10", {bus.plus, bus.minus}); end
   endtask

   task automatic test_cooldown();
      do_reset(); start(); bus.r = 6'd30;
      hit(); tick();
      checks++; if (bus.minus !== 1'b1) begin errors++; $display("FAIL cd_first_hit got %b want 1", bus.minus); end
      for (int i = 0; i < 5; i++) tick();
      hit(); tick();
      checks++; if (bus.minus !== 1'b0) begin errors++; $display("FAIL cd_dropped got %b want 0", bus.minus); end
      for (int i = 0; i < 24; i++) tick();   // 30 ticks after the grant in total
      hit(); tick();
      checks++; if (bus.minus !== 1'b1) begin errors++; $display("FAIL cd_expired got %b want 1", bus.minus); end
   endtask

   task automatic test_over();
      do_reset(); start(); bus.r = 6'd30;
      eat(); tick();
      bus.r = 6'd10;
      hit(); tick();
      checks++; if ({bus.gameover, bus.gamerun, bus.minus} !== 3'b100) begin errors++; $display("FAIL over_enter got over,run,minus=%b want 100", {bus.gameover, bus.gamerun, bus.minus}); end
      checks++; if (bus.score !== 8'd1) begin errors++; $display("FAIL over_score got %0d want 1", bus.score); end
      start();
      checks++; if (bus.gamemenu !== 1'b1) begin errors++; $display("FAIL over_to_menu got %b want 1", bus.gamemenu); end
      start();
      checks++; if ({bus.gamerun, bus.score} !== {1'b1, 8'd0}) begin errors++; $display("FAIL restart got run=%b score=%0d want 1 0", bus.gamerun, bus.score); end
   endtask

   task automatic test_pause();
      do_reset(); start(); bus.r = 6'd30;
      eat(); pause();
      checks++; if (bus.gamepause !== 1'b1) begin errors++; $display("FAIL pause_enter got %b want 1", bus.gamepause); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.plus !== 1'b0) begin errors++; $display("FAIL pause_no_grant got %b want 0", bus.plus); end
      end
      eat();                                  // dropped while paused
      pause();
      checks++; if (bus.gamerun !== 1'b1) begin errors++; $display("FAIL pause_resume got %b want 1", bus.gamerun); end
      tick();
      checks++; if (bus.plus !== 1'b1) begin errors++; $display("FAIL pause_held_eat got %b want 1", bus.plus); end
      tick();
      checks++; if (bus.plus !== 1'b0) begin errors++; $display("FAIL pause_drop got %b want 0", bus.plus); end
      pause();
      bus.btn_start = 1; bus.btn_pause = 1; step(); bus.btn_start = 0; bus.btn_pause = 0;
      checks++; if ({bus.gamemenu, bus.gamerun} !== 2'b10) begin errors++; $display("FAIL pause_start_prio got %b want 10", {bus.gamemenu, bus.gamerun}); end
   endtask

   task automatic test_boundary();
      do_reset(); start();
      bus.r = 6'd50; eat(); tick();
      checks++; if ({bus.plus, bus.score} !== {1'b0, 8'd1}) begin errors++; $display("FAIL rmax_eat got plus=%b score=%0d want 0 1", bus.plus, bus.score); end
      bus.r = 6'd49; eat(); tick();
      checks++; if ({bus.plus, bus.score} !== {1'b1, 8'd2}) begin errors++; $display("FAIL below_rmax got plus=%b score=%0d want 1 2", bus.plus, bus.score); end
      bus.r = 6'd11; hit(); tick();
      checks++; if ({bus.minus, bus.gamerun} !== 2'b11) begin errors++; $display("FAIL above_rmin got minus=%b run=%b want 1 1", bus.minus, bus.gamerun); end
      bus.eat_req = 1; bus.frame_tick = 1; step(); bus.eat_req = 0; bus.frame_tick = 0;
      checks++; if (bus.plus !== 1'b0) begin errors++; $display("FAIL same_cycle_req got %b want 0", bus.plus); end
      tick();
      checks++; if (bus.plus !== 1'b1) begin errors++; $display("FAIL same_cycle_next got %b want 1", bus.plus); end
   endtask

`ifdef AUTO_SHRINK_EN
   task automatic test_shrink();
      do_reset(); start(); bus.r = 6'd30;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++; if (bus.minus !== 1'b0) begin errors++; $display("FAIL shrink_early tick %0d got %b want 0", i, bus.minus); end
      end
      tick();
      checks++; if (bus.minus !== 1'b1) begin errors++; $display("FAIL shrink_tick5 got %b want 1", bus.minus); end
      hit(); tick();                          // no cooldown was loaded by the shrink
      checks++; if (bus.minus !== 1'b1) begin errors++; $display("FAIL shrink_no_cd got %b want 1", bus.minus); end
      do_reset(); start(); bus.r = 6'd10;
      for (int i = 0; i < 5; i++) tick();
      checks++; if ({bus.minus, bus.gameover, bus.gamerun} !== 3'b001) begin errors++; $display("FAIL shrink_rmin got minus,over,run=%b want 001", {bus.minus, bus.gameover, bus.gamerun}); end
   endtask
`endif

   initial begin
      test_reset();
      test_eat();
      test_reset_mid();
`ifdef AUTO_SHRINK_EN
      test_shrink();
`else
      test_contest();
      test_cooldown();
      test_over();
      test_pause();
      test_boundary();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
